// File: rtl/gelato_fetch_scheduler.sv
// Fetch scheduler: each cycle picks one eligible warp round-robin and issues its
// PC to the fetch stage through a valid/ready register slice. An issued warp stays
// busy until the split table re-activates it.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rdy                global enable; all state holds when low
//   pc_valid, pc       per-warp PC-table entries (warp i at [i*PC_W +: PC_W])
//   split_num          per-warp split-table entry index, packed like pc
//   activate_valid     clear busy for activate_warp_num
//   fetch_*            registered fetch request, valid/ready handshake
//   busy_mask          warps issued and awaiting activate
module gelato_fetch_scheduler #(
  parameter int unsigned WARP_NUM = 4,
  parameter int unsigned WARP_W   = 2,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned SPLIT_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic [WARP_NUM-1:0]         pc_valid,
  input  logic [WARP_NUM*PC_W-1:0]    pc,
  input  logic [WARP_NUM*SPLIT_W-1:0] split_num,
  input  logic                        activate_valid,
  input  logic [WARP_W-1:0]           activate_warp_num,
  output logic                        fetch_valid,
  input  logic                        fetch_ready,
  output logic [PC_W-1:0]             fetch_pc,
  output logic [WARP_W-1:0]           fetch_warp_num,
  output logic [SPLIT_W-1:0]          fetch_split_num,
  output logic [WARP_NUM-1:0]         busy_mask
);

  logic [PC_W-1:0]    pc_arr    [WARP_NUM];
  logic [SPLIT_W-1:0] split_arr [WARP_NUM];
  logic [WARP_NUM-1:0] elig;
  logic [WARP_NUM-1:0] busy_nxt;
  logic [WARP_W-1:0]   rr_ptr;
  logic [WARP_W-1:0]   idx;
  logic [WARP_W-1:0]   sel_warp;
  logic                sel_found;
  logic                can_load;

  // Unpack the flat per-warp buses so they can be indexed by warp number
  always_comb begin
    for (int i = 0; i < int'(WARP_NUM); i++) begin
      pc_arr[i]    = pc[i*PC_W +: PC_W];
      split_arr[i] = split_num[i*SPLIT_W +: SPLIT_W];
    end
  end

  assign elig     = pc_valid & ~busy_mask;
  assign can_load = ~fetch_valid | fetch_ready;

  // Round-robin search from rr_ptr; first eligible warp wins
  always_comb begin
    sel_found = 1'b0;
    sel_warp  = '0;
    idx       = '0;
    for (int k = 0; k < int'(WARP_NUM); k++) begin
      idx = rr_ptr + WARP_W'(k);
      if (!sel_found && elig[idx]) begin
        sel_found = 1'b1;
        sel_warp  = idx;
      end
    end
  end

  // Activate clears first, then issue sets; a same-cycle pair never collides on a busy warp
  always_comb begin
    busy_nxt = busy_mask;
    if (activate_valid) busy_nxt[activate_warp_num] = 1'b0;
    if (can_load && sel_found) busy_nxt[sel_warp] = 1'b1;
  end

  // Output slice, busy tracking and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid     <= 1'b0;
      fetch_pc        <= '0;
      fetch_warp_num  <= '0;
      fetch_split_num <= '0;
      busy_mask       <= '0;
      rr_ptr          <= '0;
    end else if (rdy) begin
      busy_mask <= busy_nxt;
      if (can_load) begin
        fetch_valid <= sel_found;
        if (sel_found) begin
          fetch_pc        <= pc_arr[sel_warp];
          fetch_split_num <= split_arr[sel_warp];
          fetch_warp_num  <= sel_warp;
          rr_ptr          <= sel_warp + WARP_W'(1);
        end
      end
    end
  end

endmodule
